// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and constants for the UART transmit arbiter
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int DRAIN_MIN = 2;
  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, search starts one past ptr_i
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic [2:0]   idx_o,
  output logic         found_o
);
  logic [N-1:0] rot;
  always_comb begin
    rot = N'({req_i, req_i} >> ((int'(ptr_i) + 1) % N));
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) idx_o = 3'((int'(ptr_i) + 1 + k) % N);
    found_o = |req_i;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter with optional grant lock feeding one UART transmitter
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NREQ = 4,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_clear_req,
  input  logic                   tx_busy,
  output logic [2:0]             grant_id,
  output logic                   locked,
  output logic [15:0]            bytes_sent
);
  state_e state_q, state_d;
  logic [2:0] ptr_q, ptr_d, grant_q, grant_d, pick;
  logic locked_q, locked_d, found, accept, drain_done;
  logic [15:0] idle_q, idle_d, bytes_q, bytes_d;
  logic [1:0] drain_q, drain_d;
  logic [7:0] data_q, data_d, data_pick;
  logic [NREQ-1:0] ready_q, ready_d, gmask, pmask, elig;

  assign gmask = NREQ'(1) << grant_q;
  assign pmask = NREQ'(1) << pick;
  // While locked only the lock holder may be picked
  assign elig = locked_q ? (req_valid & gmask) : req_valid;
  assign accept = (state_q == IDLE) && found;
  assign drain_done = drain_q >= 2'(DRAIN_MIN - 1);

  rr_pick #(.N(NREQ)) u_pick (
    .req_i   (elig),
    .ptr_i   (ptr_q),
    .idx_o   (pick),
    .found_o (found)
  );

  always_comb begin
    data_pick = '0;
    for (int k = 0; k < NREQ; k++)
      if (pick == 3'(k)) data_pick = req_data[k*BYTE_W +: BYTE_W];
  end

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    locked_d = locked_q;
    idle_d = idle_q;
    drain_d = '0;
    data_d = data_q;
    ready_d = '0;
    bytes_d = bytes_q;
    if (!locked_q) idle_d = '0;
    else if (state_q == IDLE && !(|(req_valid & gmask))) begin
      idle_d = idle_q + 16'd1;
      if (idle_q == 16'(LOCK_TIMEOUT)) begin
        locked_d = 1'b0;
        idle_d = '0;
      end
    end
    if (accept) begin
      state_d = SEND;
      ptr_d = pick;
      grant_d = pick;
      locked_d = |(req_lock & pmask);
      idle_d = '0;
      data_d = data_pick;
      ready_d = pmask;
    end
    if (state_q == SEND && tx_clear_req) state_d = DRAIN;
    if (state_q == DRAIN) begin
      drain_d = drain_done ? drain_q : drain_q + 2'd1;
      if (drain_done && !tx_busy) begin
        state_d = IDLE;
        bytes_d = bytes_q + 16'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state_q <= IDLE;
      ptr_q <= 3'(NREQ - 1);
      grant_q <= '0;
      locked_q <= 1'b0;
      idle_q <= '0;
      drain_q <= '0;
      data_q <= '0;
      ready_q <= '0;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      locked_q <= locked_d;
      idle_q <= idle_d;
      drain_q <= drain_d;
      data_q <= data_d;
      ready_q <= ready_d;
      bytes_q <= bytes_d;
    end

  assign tx_start = state_q == SEND;
  assign tx_data = data_q;
  assign req_ready = ready_q;
  assign grant_id = grant_q;
  assign locked = locked_q;
  assign bytes_sent = bytes_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenario bench for the UART transmit arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0, rst;
  logic [3:0] req_valid, req_lock, req_ready;
  logic [31:0] req_data;
  logic [7:0] tx_data;
  logic tx_start, tx_clear_req, tx_busy, locked;
  logic [2:0] grant_id;
  logic [15:0] bytes_sent;
  int checks = 0, failures = 0;
  logic [7:0] data_tab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(4), .LOCK_TIMEOUT(8)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_lock     (req_lock),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_clear_req (tx_clear_req),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .locked       (locked),
    .bytes_sent   (bytes_sent)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    req_data = 32'h44332211;
    tx_clear_req = 1'b0;
    tx_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // From SEND: clear, two DRAIN cycles, then back in IDLE with the count bumped
  task automatic finish_byte();
    tx_clear_req = 1'b1;
    tick();
    tx_clear_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (grant_id !== 3'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (bytes_sent !== 16'h0000) begin failures++; $display("FAIL reset_bytes got=%h exp=0000", bytes_sent); end
  endtask

  task automatic test_single_byte();
    req_data[23:16] = 8'h41;
    req_valid = 4'b0100;
    tick();
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", tx_start); end
    checks++; if (tx_data !== 8'h41) begin failures++; $display("FAIL single_data got=%h exp=41", tx_data); end
    checks++; if (grant_id !== 3'd2) begin failures++; $display("FAIL single_grant got=%0d exp=2", grant_id); end
    req_valid = 4'b0000;
    req_data[23:16] = 8'hFF;
    tick();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_pulse got=%b exp=0000", req_ready); end
    checks++; if (tx_data !== 8'h41) begin failures++; $display("FAIL single_hold got=%h exp=41", tx_data); end
    finish_byte();
    checks++; if (bytes_sent !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bytes_sent); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_stop got=%b exp=0", tx_start); end
  endtask

  task automatic test_ignored_inputs();
    tx_clear_req = 1'b1;
    tx_busy = 1'b1;
    tick();
    tx_clear_req = 1'b0;
    tx_busy = 1'b0;
    tick();
    checks++; if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL ignored_idle got=%b/%b exp=0/0000", tx_start, req_ready); end
    checks++; if (bytes_sent !== 16'd1) begin failures++; $display("FAIL ignored_count got=%0d exp=1", bytes_sent); end
  endtask

  task automatic test_fairness();
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (req_ready !== 4'(1 << (i % 4))) begin failures++; $display("FAIL fair_ready[%0d] got=%b exp=%b", i, req_ready, 4'(1 << (i % 4))); end
      checks++; if (tx_data !== data_tab[i % 4]) begin failures++; $display("FAIL fair_data[%0d] got=%h exp=%h", i, tx_data, data_tab[i % 4]); end
      finish_byte();
    end
    checks++; if (bytes_sent !== 16'd6) begin failures++; $display("FAIL fair_count got=%0d exp=6", bytes_sent); end
  endtask

  task automatic test_lock();
    do_reset();
    req_valid = 4'b0010;
    req_lock = 4'b0010;
    tick();
    checks++; if (req_ready !== 4'b0010 || locked !== 1'b1) begin failures++; $display("FAIL lock_first got=%b/%b exp=0010/1", req_ready, locked); end
    req_valid = 4'b1011;
    finish_byte();
    tick();
    checks++; if (req_ready !== 4'b0010 || locked !== 1'b1) begin failures++; $display("FAIL lock_second got=%b/%b exp=0010/1", req_ready, locked); end
    req_lock = 4'b0000;
    finish_byte();
    tick();
    checks++; if (req_ready !== 4'b0010 || locked !== 1'b0) begin failures++; $display("FAIL lock_third got=%b/%b exp=0010/0", req_ready, locked); end
    finish_byte();
    tick();
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL lock_after3 got=%b exp=1000", req_ready); end
    finish_byte();
    tick();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL lock_after0 got=%b exp=0001", req_ready); end
    finish_byte();
  endtask

  task automatic test_lock_timeout();
    logic stray;
    do_reset();
    req_valid = 4'b0100;
    req_lock = 4'b0100;
    tick();
    checks++; if (locked !== 1'b1 || grant_id !== 3'd2) begin failures++; $display("FAIL tmo_lock got=%b/%0d exp=1/2", locked, grant_id); end
    req_valid = 4'b0001;
    req_lock = 4'b0000;
    finish_byte();
    stray = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      if (locked !== 1'b1 || req_ready !== 4'b0000) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin failures++; $display("FAIL tmo_hold got=early_release_or_grant exp=locked_9_cycles"); end
    tick();
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", locked); end
    tick();
    checks++; if (req_ready !== 4'b0001 || grant_id !== 3'd0) begin failures++; $display("FAIL tmo_next got=%b/%0d exp=0001/0", req_ready, grant_id); end
    finish_byte();
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    req_valid = 4'b0010;
    tick();
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL rst_send got=%b exp=1", tx_start); end
    req_valid = 4'b0110;
    rst = 1'b1;
    tx_clear_req = 1'b1;
    tick();
    checks++; if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL rst_abandon got=%b/%b exp=0/0000", tx_start, req_ready); end
    checks++; if (bytes_sent !== 16'd0 || tx_data !== 8'h00) begin failures++; $display("FAIL rst_state got=%h/%h exp=0000/00", bytes_sent, tx_data); end
    rst = 1'b0;
    tx_clear_req = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rst_pointer got=%b exp=0010", req_ready); end
    finish_byte();
    checks++; if (bytes_sent !== 16'd1) begin failures++; $display("FAIL rst_count got=%0d exp=1", bytes_sent); end
  endtask

  task automatic test_wrap_and_stuck();
    logic stray;
    req_valid = 4'b0000;
    force dut.bytes_q = 16'hFFFF;
    @(negedge clk);
    release dut.bytes_q;
    tick();
    checks++; if (bytes_sent !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", bytes_sent); end
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    finish_byte();
    checks++; if (bytes_sent !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=0000", bytes_sent); end
    tx_busy = 1'b1;
    req_valid = 4'b0001;
    tick();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL stuck_accept got=%b exp=0001", req_ready); end
    tx_clear_req = 1'b1;
    tick();
    tx_clear_req = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (req_ready !== 4'b0000 || tx_start !== 1'b0 || bytes_sent !== 16'h0000) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin failures++; $display("FAIL stuck_hold got=activity exp=held_in_drain"); end
    tx_busy = 1'b0;
    tick();
    checks++; if (bytes_sent !== 16'd1) begin failures++; $display("FAIL stuck_release got=%0d exp=1", bytes_sent); end
    tick();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL stuck_next got=%b exp=0001", req_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_byte();
    test_ignored_inputs();
    test_fairness();
    test_lock();
    test_lock_timeout();
    test_reset_mid_send();
    test_wrap_and_stuck();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of byte requesters (legal range 2..8).
REQ-002 Parameter LOCK_TIMEOUT, default 1023, SHALL set the number of idle cycles after which a held lock is dropped (legal range 1..65535).
REQ-003 wb_clk_i  in  1  SHALL be the single clock; every register samples on its rising edge.
REQ-004 wb_rst_i  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_valid  in  NREQ  SHALL be the per-requester flags meaning "byte available".
REQ-006 req_data  in  8*NREQ  SHALL carry the byte for requester i on bits [8i+7:8i].
REQ-007 req_lock  in  NREQ  SHALL be a per-requester request to keep the grant after the current byte.
REQ-008 req_ready  out  NREQ  SHALL pulse one-hot for one cycle when that requester's byte is accepted.
REQ-009 tx_data  out  8  SHALL drive the byte to the transmitter.
REQ-010 tx_start  out  1  SHALL be the transmit request, held until cleared.
REQ-011 tx_clear_req  in  1  SHALL be the transmitter pulse meaning "byte latched, drop tx_start".
REQ-012 tx_busy  in  1  SHALL be high while the transmitter is shifting.
REQ-013 grant_id  out  3  SHALL show the index of the requester whose byte is in flight or that holds the lock.
REQ-014 locked  out  1  SHALL be high while a lock is held.
REQ-015 bytes_sent  out  16  SHALL count completed bytes, wrapping from 0xFFFF to 0.

Function
REQ-016 The FSM SHALL have the states IDLE, SEND and DRAIN.
REQ-017 IDLE: if any eligible req_valid is set, the block SHALL latch that requester's req_data into tx_data, pulse its req_ready, record req_lock, and enter SEND on the next cycle.
REQ-018 Eligibility: with locked=0 all requesters SHALL be eligible; with locked=1 only grant_id SHALL be eligible.
REQ-019 Arbitration SHALL be round-robin: search starts at (last granted index + 1) mod NREQ; after reset, search starts at index 0.
REQ-020 SEND: tx_start SHALL be 1; on tx_clear_req=1 tx_start SHALL fall on the next cycle and the FSM SHALL enter DRAIN.
REQ-021 DRAIN: the FSM SHALL stay at least 2 cycles, then return to IDLE on the first cycle tx_busy=0, incrementing bytes_sent by 1 in that transition.
REQ-022 Acceptance-to-tx_start latency SHALL be 1 cycle; at most one byte SHALL be accepted per IDLE visit.
REQ-023 The lock SHALL be set when a byte is accepted with req_lock=1, and cleared when a byte is accepted with req_lock=0.
REQ-024 While locked=1 and in IDLE with req_valid[grant_id]=0, an idle counter SHALL increment; when it reaches LOCK_TIMEOUT, locked SHALL clear on the next cycle.
REQ-025 The idle counter SHALL reset to 0 on any acceptance or when locked=0.
REQ-026 Simultaneous requests SHALL produce exactly one req_ready; the others stay 0 and their data is untouched.
REQ-027 tx_clear_req outside SEND SHALL be ignored; a tx_busy change outside DRAIN SHALL be ignored.
REQ-028 req_valid dropping after acceptance SHALL NOT affect the in-flight byte.

Reset
REQ-029 On wb_rst_i=1 the block SHALL set: state=IDLE, tx_start=0, tx_data=0x00, req_ready=0, grant_id=0, locked=0, bytes_sent=0, idle counter=0, round-robin pointer=NREQ-1.
REQ-030 Reset mid-SEND/DRAIN SHALL abandon the byte without a req_ready or count; reset SHALL take priority over every other event in the same cycle.

Structure
REQ-031 A shared package uart_pkg SHALL hold the state enum type (IDLE/SEND/DRAIN), the DRAIN_MIN=2 constant and the byte-width constant 8.
REQ-032 The round-robin priority pick SHALL be one combinational sub-module, rr_pick (inputs: request vector, pointer; output: index and found flag); all other logic SHALL be in uart_tx_arbiter.

Verification
REQ-033 Single byte: req_valid[2]=1, data 0x41 -> req_ready[2] pulses once, tx_data=0x41 with tx_start=1 next cycle, bytes_sent=1 after drain.
REQ-034 Fairness: all 4 valid continuously with lock=0 -> grant order 0,1,2,3,0,1,... with no requester skipped.
REQ-035 Lock: req 1 sends 3 bytes with lock=1,1,0 while req 0 and req 3 are valid -> bytes 1,1,1 then 2? no: 1,1,1, then 3,0 by round-robin; locked falls after the third acceptance.
REQ-036 Lock timeout with LOCK_TIMEOUT=8: req 2 locks, then drops valid -> locked clears 9 cycles later and req 0 is granted next.
REQ-037 Reset mid-SEND: wb_rst_i asserted before tx_clear_req -> tx_start=0 next cycle, bytes_sent unchanged at 0, pointer reset.
REQ-038 Wrap: preload bytes_sent=0xFFFF and complete one byte -> bytes_sent=0x0000; tx_busy stuck at 1 -> the FSM holds in DRAIN and accepts nothing.
